// File: rtl/pa_noc.sv
// Shared NoC definitions: packet layout, field offsets and the NI transmit FSM states.
package pa_noc;

    localparam int unsigned PACKET_WIDTH  = 32;
    localparam int unsigned PAYLOAD_WIDTH = PACKET_WIDTH - 8;
    localparam int unsigned COORD_WIDTH   = 2;

    localparam int unsigned DEST_COL_LSB = 0;
    localparam int unsigned DEST_ROW_LSB = 2;
    localparam int unsigned SRC_COL_LSB  = 4;
    localparam int unsigned SRC_ROW_LSB  = 6;
    localparam int unsigned PAYLOAD_LSB  = 8;

    typedef struct packed {
        logic [PAYLOAD_WIDTH-1:0] payload;
        logic [COORD_WIDTH-1:0]   srcRow;
        logic [COORD_WIDTH-1:0]   srcCol;
        logic [COORD_WIDTH-1:0]   destRow;
        logic [COORD_WIDTH-1:0]   destCol;
    } packet_t;

    typedef enum logic {IDLE, HOLD} tx_state_t;

    function automatic packet_t buildPacket(
        input logic [PAYLOAD_WIDTH-1:0] payload,
        input logic [COORD_WIDTH-1:0]   srcRow,
        input logic [COORD_WIDTH-1:0]   srcCol,
        input logic [COORD_WIDTH-1:0]   destRow,
        input logic [COORD_WIDTH-1:0]   destCol
    );
        packet_t p;
        p.payload = payload;
        p.srcRow  = srcRow;
        p.srcCol  = srcCol;
        p.destRow = destRow;
        p.destCol = destCol;
        return p;
    endfunction

endpackage

// File: rtl/ni_rx_buffer.sv
// First-word-fall-through FIFO for the NI receive path; full/empty plus a two-free-slots flag.
module ni_rx_buffer #(
    parameter int unsigned ADDRESS_WIDTH = 2,
    parameter int unsigned DATA_WIDTH    = 32
) (
    input  logic                  i_clk,
    input  logic                  i_arst,
    input  logic                  i_wrEn,
    input  logic [DATA_WIDTH-1:0] i_wrData,
    input  logic                  i_rdEn,
    output logic [DATA_WIDTH-1:0] o_rdData,
    output logic                  o_full,
    output logic                  o_empty,
    output logic                  o_twoFree
);

    localparam int unsigned DEPTH = 1 << ADDRESS_WIDTH;
    localparam logic [ADDRESS_WIDTH:0] FULL_COUNT = {1'b1, {ADDRESS_WIDTH{1'b0}}};

    logic [DATA_WIDTH-1:0]    mem [DEPTH];
    logic [ADDRESS_WIDTH-1:0] wrPtrQ, rdPtrQ;
    logic [ADDRESS_WIDTH:0]   countQ;
    logic                     push, pop;

    assign o_full    = (countQ == FULL_COUNT);
    assign o_empty   = (countQ == '0);
    assign o_twoFree = ((32'(countQ) + 32'd2) <= DEPTH);
    assign push      = i_wrEn && !o_full;
    assign pop       = i_rdEn && !o_empty;
    assign o_rdData  = mem[rdPtrQ];

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wrPtrQ] <= i_wrData;
        end
    end

    // Pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            wrPtrQ <= '0;
            rdPtrQ <= '0;
            countQ <= '0;
        end else begin
            if (push) wrPtrQ <= wrPtrQ + 1'b1;
            if (pop)  rdPtrQ <= rdPtrQ + 1'b1;
            if (push && !pop)      countQ <= countQ + 1'b1;
            else if (pop && !push) countQ <= countQ - 1'b1;
        end
    end

endmodule

// File: rtl/network_interface.sv
// Tile endpoint on a router NI port: TX packet builder/injector and buffered RX delivery.
// Define NI_STATS_EN to add saturating TX/RX packet counters.
module network_interface
    import pa_noc::*;
#(
    parameter int unsigned GRID_WIDTH            = 4,
    parameter int unsigned NI_ROW                = 0,
    parameter int unsigned NI_COL                = 0,
    parameter int unsigned RX_FIFO_ADDRESS_WIDTH = 2
) (
    input  logic                     i_clk,
    input  logic                     i_arst,
    input  logic                     i_txValid,
    output logic                     o_txReady,
    input  logic [1:0]               i_txDestRow,
    input  logic [1:0]               i_txDestCol,
    input  logic [PAYLOAD_WIDTH-1:0] i_txPayload,
    output logic [PACKET_WIDTH-1:0]  o_toRouter,
    output logic                     o_toRouterValid,
    input  logic                     i_toRouterReady,
    input  logic [PACKET_WIDTH-1:0]  i_fromRouter,
    input  logic                     i_fromRouterValid,
    output logic                     o_fromRouterReady,
    output logic                     o_rxValid,
    input  logic                     i_rxReady,
    output logic [PAYLOAD_WIDTH-1:0] o_rxPayload,
    output logic [1:0]               o_rxSrcRow,
    output logic [1:0]               o_rxSrcCol,
    output logic                     o_rxOverflow
`ifdef NI_STATS_EN
    ,
    output logic [15:0]              o_txCount,
    output logic [15:0]              o_rxCount
`endif
);

    localparam logic [COORD_WIDTH-1:0] SRC_ROW = COORD_WIDTH'(NI_ROW % GRID_WIDTH);
    localparam logic [COORD_WIDTH-1:0] SRC_COL = COORD_WIDTH'(NI_COL % GRID_WIDTH);

    // ---------------- TX path ----------------
    tx_state_t txStateQ, txStateD;
    packet_t   holdQ, holdD;

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            txStateQ <= IDLE;
            holdQ    <= '0;
        end else begin
            txStateQ <= txStateD;
            holdQ    <= holdD;
        end
    end

    // Valid is combinational on router ready: the router FIFO writes on valid alone.
    always_comb begin
        txStateD        = txStateQ;
        holdD           = holdQ;
        o_txReady       = 1'b0;
        o_toRouter      = '0;
        o_toRouterValid = 1'b0;
        unique case (txStateQ)
            IDLE: begin
                o_txReady = 1'b1;
                if (i_txValid) begin
                    holdD    = buildPacket(i_txPayload, SRC_ROW, SRC_COL, i_txDestRow,
                                           i_txDestCol);
                    txStateD = HOLD;
                end
            end
            HOLD: begin
                o_toRouter      = holdQ;
                o_toRouterValid = i_toRouterReady;
                if (i_toRouterReady) txStateD = IDLE;
            end
        endcase
    end

    // ---------------- RX path ----------------
    packet_t rxHead;
    logic    rxFull, rxEmpty, rxTwoFree, rxWrite, rxPop;

    assign rxWrite = i_fromRouterValid && !rxFull;
    assign rxPop   = o_rxValid && i_rxReady;

    ni_rx_buffer #(
        .ADDRESS_WIDTH(RX_FIFO_ADDRESS_WIDTH),
        .DATA_WIDTH   (PACKET_WIDTH)
    ) u_rxBuffer (
        .i_clk    (i_clk),
        .i_arst   (i_arst),
        .i_wrEn   (rxWrite),
        .i_wrData (i_fromRouter),
        .i_rdEn   (rxPop),
        .o_rdData (rxHead),
        .o_full   (rxFull),
        .o_empty  (rxEmpty),
        .o_twoFree(rxTwoFree)
    );

    // Two free slots cover the packet already in flight in the router's output register.
    assign o_fromRouterReady = rxTwoFree;
    assign o_rxValid         = !rxEmpty;
    assign o_rxPayload       = rxEmpty ? '0 : rxHead.payload;
    assign o_rxSrcRow        = rxEmpty ? '0 : rxHead.srcRow;
    assign o_rxSrcCol        = rxEmpty ? '0 : rxHead.srcCol;

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            o_rxOverflow <= 1'b0;
        end else if (i_fromRouterValid && rxFull) begin
            o_rxOverflow <= 1'b1;
        end
    end

`ifdef NI_STATS_EN
    logic [15:0] txCountQ, rxCountQ;

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            txCountQ <= '0;
            rxCountQ <= '0;
        end else begin
            if (o_toRouterValid && txCountQ != 16'hFFFF) txCountQ <= txCountQ + 16'd1;
            if (rxWrite && rxCountQ != 16'hFFFF)         rxCountQ <= rxCountQ + 16'd1;
        end
    end

    assign o_txCount = txCountQ;
    assign o_rxCount = rxCountQ;
`endif

endmodule

// File: tb/tb_network_interface.sv
// Scoreboard bench for network_interface (tile at row 1, column 2, RX depth 4).
module tb_network_interface;
    import pa_noc::*;

    logic                     i_clk = 1'b0;
    logic                     i_arst;
    logic                     i_txValid;
    logic                     o_txReady;
    logic [1:0]               i_txDestRow, i_txDestCol;
    logic [PAYLOAD_WIDTH-1:0] i_txPayload;
    logic [PACKET_WIDTH-1:0]  o_toRouter;
    logic                     o_toRouterValid;
    logic                     i_toRouterReady;
    logic [PACKET_WIDTH-1:0]  i_fromRouter;
    logic                     i_fromRouterValid;
    logic                     o_fromRouterReady;
    logic                     o_rxValid;
    logic                     i_rxReady;
    logic [PAYLOAD_WIDTH-1:0] o_rxPayload;
    logic [1:0]               o_rxSrcRow, o_rxSrcCol;
    logic                     o_rxOverflow;
`ifdef NI_STATS_EN
    logic [15:0]              o_txCount, o_rxCount;
`endif

    int checks   = 0;
    int failures = 0;
    logic [PACKET_WIDTH-1:0] txQ [$];
    logic [PACKET_WIDTH-1:0] rxQ [$];

    always #5 i_clk = ~i_clk;

    network_interface #(
        .GRID_WIDTH           (4),
        .NI_ROW               (1),
        .NI_COL               (2),
        .RX_FIFO_ADDRESS_WIDTH(2)
    ) dut (
        .i_clk            (i_clk),
        .i_arst           (i_arst),
        .i_txValid        (i_txValid),
        .o_txReady        (o_txReady),
        .i_txDestRow      (i_txDestRow),
        .i_txDestCol      (i_txDestCol),
        .i_txPayload      (i_txPayload),
        .o_toRouter       (o_toRouter),
        .o_toRouterValid  (o_toRouterValid),
        .i_toRouterReady  (i_toRouterReady),
        .i_fromRouter     (i_fromRouter),
        .i_fromRouterValid(i_fromRouterValid),
        .o_fromRouterReady(o_fromRouterReady),
        .o_rxValid        (o_rxValid),
        .i_rxReady        (i_rxReady),
        .o_rxPayload      (o_rxPayload),
        .o_rxSrcRow       (o_rxSrcRow),
        .o_rxSrcCol       (o_rxSrcCol),
        .o_rxOverflow     (o_rxOverflow)
`ifdef NI_STATS_EN
        ,
        .o_txCount        (o_txCount),
        .o_rxCount        (o_rxCount)
`endif
    );

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    function automatic logic [PACKET_WIDTH-1:0] rxPkt(input logic [PAYLOAD_WIDTH-1:0] p);
        return {p, 2'd2, 2'd1, 2'd1, 2'd2};
    endfunction

    // Scoreboard monitor: outputs are stable at the falling edge.
    always @(negedge i_clk) begin
        if (!i_arst && o_toRouterValid) begin
            checkVal("tx_pending", 64'(txQ.size() > 0), 64'd1);
            if (txQ.size() > 0) checkVal("tx_packet", 64'(o_toRouter), 64'(txQ.pop_front()));
        end
        if (!i_arst && o_rxValid && i_rxReady) begin
            checkVal("rx_pending", 64'(rxQ.size() > 0), 64'd1);
            if (rxQ.size() > 0) begin
                logic [PACKET_WIDTH-1:0] e;
                e = rxQ.pop_front();
                checkVal("rx_head", 64'({o_rxPayload, o_rxSrcRow, o_rxSrcCol}), 64'(e[31:4]));
            end
        end
    end

`ifdef NI_STATS_EN
    task automatic sendTx(input logic [PAYLOAD_WIDTH-1:0] p);
        i_txPayload = p;
        i_txDestRow = 2'd0;
        i_txDestCol = 2'd3;
        i_txValid   = 1'b1;
        txQ.push_back({p, 2'd1, 2'd2, 2'd0, 2'd3});
        tick();
        i_txValid = 1'b0;
        tick();
    endtask
`endif

    initial begin
        i_arst = 1'b1; i_txValid = 1'b0; i_txDestRow = '0; i_txDestCol = '0; i_txPayload = '0;
        i_toRouterReady = 1'b0; i_fromRouter = '0; i_fromRouterValid = 1'b0; i_rxReady = 1'b0;
        #3;
        checkVal("rst_txReady", 64'(o_txReady), 64'd1);
        checkVal("rst_fromRouterReady", 64'(o_fromRouterReady), 64'd1);
        checkVal("rst_toRouterValid", 64'(o_toRouterValid), 64'd0);
        checkVal("rst_toRouter", 64'(o_toRouter), 64'd0);
        checkVal("rst_rxValid", 64'(o_rxValid), 64'd0);
        checkVal("rst_rxOverflow", 64'(o_rxOverflow), 64'd0);
        tick();
        i_arst = 1'b0;
        tick();

        // TX basic
        i_toRouterReady = 1'b1;
        i_txPayload = 24'hABCDEF; i_txDestRow = 2'd3; i_txDestCol = 2'd0; i_txValid = 1'b1;
        txQ.push_back(32'hABCDEF6C);
        #1 checkVal("tx1_ready_idle", 64'(o_txReady), 64'd1);
        tick();
        i_txValid = 1'b0;
        #1;
        checkVal("tx1_ready_hold", 64'(o_txReady), 64'd0);
        checkVal("tx1_valid", 64'(o_toRouterValid), 64'd1);
        checkVal("tx1_packet", 64'(o_toRouter), 64'hABCDEF6C);
        tick();
        checkVal("tx1_ready_back", 64'(o_txReady), 64'd1);
        checkVal("tx1_valid_drop", 64'(o_toRouterValid), 64'd0);
        checkVal("tx1_idle_zero", 64'(o_toRouter), 64'd0);

        // TX backpressure
        i_toRouterReady = 1'b0;
        i_txPayload = 24'h123456; i_txDestRow = 2'd0; i_txDestCol = 2'd1; i_txValid = 1'b1;
        txQ.push_back(32'h12345661);
        tick();
        i_txValid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            checkVal("bp_valid_low", 64'(o_toRouterValid), 64'd0);
            checkVal("bp_ready_low", 64'(o_txReady), 64'd0);
            checkVal("bp_hold", 64'(o_toRouter), 64'h12345661);
            tick();
        end
        i_toRouterReady = 1'b1;
        #1 checkVal("bp_release_valid", 64'(o_toRouterValid), 64'd1);
        tick();
        checkVal("bp_after_valid", 64'(o_toRouterValid), 64'd0);
        checkVal("bp_after_ready", 64'(o_txReady), 64'd1);

        // RX ordering
        i_rxReady = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            i_fromRouter = rxPkt(24'(k));
            i_fromRouterValid = 1'b1;
            rxQ.push_back(rxPkt(24'(k)));
            tick();
            if (k == 2) checkVal("rx_ready_two_used", 64'(o_fromRouterReady), 64'd1);
        end
        i_fromRouterValid = 1'b0;
        #1;
        checkVal("rx_ready_low", 64'(o_fromRouterReady), 64'd0);
        checkVal("rx_valid", 64'(o_rxValid), 64'd1);
        checkVal("rx_head_payload", 64'(o_rxPayload), 64'd1);
        checkVal("rx_head_src", 64'({o_rxSrcRow, o_rxSrcCol}), 64'b1001);
        i_rxReady = 1'b1;
        repeat (3) tick();
        i_rxReady = 1'b0;
        checkVal("rx_drained", 64'(o_rxValid), 64'd0);
        checkVal("rx_empty_zero", 64'(o_rxPayload), 64'd0);
        checkVal("rx_ready_back", 64'(o_fromRouterReady), 64'd1);

        // RX overflow
        for (int i = 0; i < 5; i++) begin
            i_fromRouter = rxPkt(24'(8'h10 + i));
            i_fromRouterValid = 1'b1;
            if (i < 4) rxQ.push_back(rxPkt(24'(8'h10 + i)));
            if (i == 4) checkVal("ovf_not_yet", 64'(o_rxOverflow), 64'd0);
            tick();
        end
        i_fromRouterValid = 1'b0;
        checkVal("ovf_set", 64'(o_rxOverflow), 64'd1);
        repeat (2) tick();
        checkVal("ovf_sticky", 64'(o_rxOverflow), 64'd1);
        i_rxReady = 1'b1;
        repeat (4) tick();
        i_rxReady = 1'b0;
        checkVal("ovf_drained", 64'(o_rxValid), 64'd0);
        checkVal("ovf_sticky2", 64'(o_rxOverflow), 64'd1);

        // Push and pop together on an empty buffer: no bypass
        i_fromRouter = rxPkt(24'h77);
        i_fromRouterValid = 1'b1;
        i_rxReady = 1'b1;
        rxQ.push_back(rxPkt(24'h77));
        #1 checkVal("nobypass_valid", 64'(o_rxValid), 64'd0);
        tick();
        i_fromRouterValid = 1'b0;
        #1;
        checkVal("nobypass_next", 64'(o_rxValid), 64'd1);
        checkVal("nobypass_payload", 64'(o_rxPayload), 64'h77);
        tick();
        i_rxReady = 1'b0;

        // Reset while holding a packet
        i_toRouterReady = 1'b0;
        i_txPayload = 24'hDEAD00; i_txDestRow = 2'd2; i_txDestCol = 2'd2; i_txValid = 1'b1;
        tick();
        i_txValid = 1'b0;
        #1 checkVal("rst_hold_state", 64'(o_txReady), 64'd0);
        i_arst = 1'b1;
        i_toRouterReady = 1'b1;
        #1;
        checkVal("rst_mid_valid", 64'(o_toRouterValid), 64'd0);
        checkVal("rst_mid_ready", 64'(o_txReady), 64'd1);
        checkVal("rst_mid_ovf", 64'(o_rxOverflow), 64'd0);
        tick();
        i_arst = 1'b0;
        repeat (5) tick();
        checkVal("rst_after_ready", 64'(o_txReady), 64'd1);

`ifdef NI_STATS_EN
        for (int i = 0; i < 3; i++) sendTx(24'(24'h500 + i));
        for (int i = 0; i < 2; i++) begin
            i_fromRouter = rxPkt(24'(24'h600 + i));
            i_fromRouterValid = 1'b1;
            rxQ.push_back(rxPkt(24'(24'h600 + i)));
            tick();
        end
        i_fromRouterValid = 1'b0;
        checkVal("stats_tx", 64'(o_txCount), 64'd3);
        checkVal("stats_rx", 64'(o_rxCount), 64'd2);
        i_rxReady = 1'b1;
        repeat (2) tick();
        i_rxReady = 1'b0;
        force dut.txCountQ = 16'hFFFF;
        #1 release dut.txCountQ;
        sendTx(24'h999);
        checkVal("stats_sat", 64'(o_txCount), 64'hFFFF);
`endif

        checkVal("txq_drained", 64'(txQ.size()), 64'd0);
        checkVal("rxq_drained", 64'(rxQ.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
